// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - main control FSM for a multi-cycle MIPS-style datapath
//
// Purpose:
//   Sequences fetch, decode, execute, memory access and write-back for
//   lw, sw, R-type, addi, beq and j. The state is registered and the
//   datapath controls are decoded combinationally from it (Moore). The
//   only terms that also depend on inputs are the mem_ready-gated
//   controls, the MEM_WRITE completion pulse, the illegal-op pulse in
//   DECODE and pc_en.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   op[5:0]              opcode from IR[31:26], sampled in DECODE and MEM_ADDR
//   zero                 ALU zero flag, used only for the branch PC enable
//   mem_ready            memory handshake, access completes while high
//   pc_en                pc_write | (pc_write_cond & zero)
//   pc_write_cond        branch PC write
//   iord                 memory address select (0 PC, 1 ALUOut)
//   mem_read, mem_write  memory strobes
//   ir_write             instruction register load
//   mem_to_reg           write-data select (1 MDR)
//   reg_dst              destination select (1 rd, 0 rt)
//   reg_write            register file write enable
//   alu_src_a            ALU A select (0 PC, 1 A)
//   alu_src_b[1:0]       ALU B select (B, 4, imm, imm<<2)
//   aluop[1:0]           ALU control (add, sub, funct)
//   pc_source[1:0]       PC source (ALU, ALUOut, jump target)
//   instr_done           pulse in the last cycle of each instruction
//   illegal_op           pulse when DECODE sees an unsupported opcode
//   state[3:0]           current state, for debug

module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_e state_q, state_d;
  logic   op_legal;
  logic   pc_write;

  assign op_legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                    (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);

  // Next-state logic. Unused codes 12-15 fall through to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      // Second opcode look: lw and sw share the address calculation.
      S_MEM_ADDR:  state_d = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC:      state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode. Reset overrides everything so nothing is strobed
  // while rst is high, even before the state register has been cleared.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aluop         = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC update only in the cycle the fetch completes.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (!op_legal) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        aluop     = 2'b10;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
      end
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      aluop         = 2'b00;
      pc_source     = 2'b00;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
    end
  end

  assign pc_en = pc_write | (pc_write_cond & zero);
  assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - self-checking bench for multi_cycle_ctrl
//
// The reference model describes each instruction as the list of states it
// walks through (chosen by opcode when DECODE completes) plus the stall
// rule for the memory-waiting steps; the expected controls come from the
// per-state output table. A compare process checks every cycle; directed
// tests pin cycle counts and key outputs with literal values.

module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, aluop, pc_source;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  multi_cycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_en;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } outs_t;

  outs_t act;
  assign act = '{pc_en, pc_write_cond, iord, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, aluop,
                 pc_source, instr_done, illegal_op};

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, a, e, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_legal(input logic [5:0] o);
    return (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
           (o == 6'b000100) || (o == 6'b000010) || (o == 6'b001000);
  endfunction

  // Number of steps in an instruction given its opcode.
  function automatic int path_len(input logic [5:0] o);
    case (o)
      6'b100011:                       return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010:            return 3;
      default:                         return 2;
    endcase
  endfunction

  // State number visited at step idx of an instruction.
  function automatic int path_state(input int idx, input logic [5:0] o);
    if (idx == 0) return 0;
    if (idx == 1) return 1;
    case (o)
      6'b100011: return idx;              // 2,3,4
      6'b101011: return (idx == 2) ? 2 : 5;
      6'b000000: return idx + 4;          // 6,7
      6'b001000: return idx + 8;          // 10,11
      6'b000100: return 8;
      6'b000010: return 9;
      default:   return 0;
    endcase
  endfunction

  function automatic bit is_wait(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  function automatic bit exp_pcw(input int s, input logic mr, input logic r);
    if (r) return 1'b0;
    return ((s == 0) && mr) || (s == 9);
  endfunction

  function automatic outs_t exp_outs(input int s, input logic mr, input logic z,
                                     input logic [5:0] o, input logic r);
    outs_t e;
    e = '0;
    if (r) return e;
    case (s)
      0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; end
      1:  begin e.alu_src_b = 2'b11;
                if (!is_legal(o)) begin e.illegal_op = 1; e.instr_done = 1; end end
      2, 10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      3:  begin e.mem_read = 1; e.iord = 1; end
      4:  begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
      5:  begin e.mem_write = 1; e.iord = 1; e.instr_done = mr; end
      6:  begin e.alu_src_a = 1; e.aluop = 2'b10; end
      7:  begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
      8:  begin e.alu_src_a = 1; e.aluop = 2'b01; e.pc_write_cond = 1;
                e.pc_source = 2'b01; e.instr_done = 1; end
      9:  begin e.pc_source = 2'b10; e.instr_done = 1; end
      11: begin e.reg_write = 1; e.instr_done = 1; end
      default: ;
    endcase
    e.pc_en = exp_pcw(s, mr, r) | (e.pc_write_cond & z);
    return e;
  endfunction

  int         m_idx = 0;
  int         m_len = 2;
  logic [5:0] m_op  = 6'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_idx <= 0;
      m_len <= 2;
    end else if (!(is_wait(path_state(m_idx, m_op)) && !mem_ready)) begin
      if (m_idx == 1) begin
        m_op  <= op;
        m_len <= path_len(op);
        m_idx <= (path_len(op) > 2) ? 2 : 0;
      end else if (m_idx + 1 >= m_len) begin
        m_idx <= 0;
        m_len <= 2;
      end else begin
        m_idx <= m_idx + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int    es;
    outs_t eo;
    if (chk_en) begin
      es = path_state(m_idx, m_op);
      eo = exp_outs(es, mem_ready, zero, op, rst);
      check("state", {28'b0, state}, es);
      check("outputs", {14'b0, act}, {14'b0, eo});
      check("inv_mem_rw", {31'b0, mem_read & mem_write}, 0);
      check("inv_reg_ir", {31'b0, reg_write & ir_write}, 0);
      check("pc_en_eq", {31'b0, pc_en},
            {31'b0, exp_pcw(es, mem_ready, rst) | (pc_write_cond & zero)});
    end
  end

  // ---------------- directed stimulus ----------------
  int cyc, done_cnt, mw_cnt, rw_cnt, il_cnt, we_cnt, br_pcen, br_aluop;
  int seq [0:15];

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #2;
  endtask

  // Runs one instruction starting in FETCH; sf/sm are the number of
  // mem_ready-low cycles in FETCH and in MEM_READ/MEM_WRITE; o_late is
  // driven onto op once the opcode can no longer matter.
  task automatic run_instr(input logic [5:0] o, input logic z, input logic [5:0] o_late,
                           input int sf, input int sm);
    int nsf, nsm;
    bit done;
    op = o; zero = z; nsf = sf; nsm = sm; done = 0;
    cyc = 0; done_cnt = 0; mw_cnt = 0; rw_cnt = 0; il_cnt = 0; we_cnt = 0;
    br_pcen = -1; br_aluop = -1;
    for (int i = 0; i < 16; i++) seq[i] = -1;
    while (!done && cyc < 40) begin
      if (state == 4'd0 && nsf > 0) begin mem_ready = 0; nsf--; end
      else if ((state == 4'd3 || state == 4'd5) && nsm > 0) begin mem_ready = 0; nsm--; end
      else mem_ready = 1;
      if (state > 4'd2 && state != 4'd5) op = o_late;
      @(negedge clk);
      if (cyc < 16) seq[cyc] = state;
      cyc++;
      done_cnt += instr_done;
      mw_cnt   += mem_write;
      rw_cnt   += reg_write;
      il_cnt   += illegal_op;
      if (state != 4'd0)
        we_cnt += (mem_write | reg_write | ir_write | pc_en | pc_write_cond);
      if (state == 4'd8) begin br_pcen = pc_en; br_aluop = aluop; end
      done = instr_done;
      @(posedge clk);
      #2;
    end
    if (!done) check("instr_timeout", 0, 1);
    mem_ready = 1;
  endtask

  initial begin
    rst = 1; op = 6'b0; zero = 0; mem_ready = 1;
    @(posedge clk); #2;
    chk_en = 1;
    @(negedge clk);
    check("rst_outs", {14'b0, act}, 0);
    check("rst_state", {28'b0, state}, 0);
    @(posedge clk); #2;
    rst = 0; mem_ready = 0;
    @(negedge clk);
    check("fetch_wait_mem_read", {31'b0, mem_read}, 1);
    check("fetch_wait_ir_write", {31'b0, ir_write}, 0);
    check("fetch_wait_alu_src_b", {30'b0, alu_src_b}, 1);
    @(posedge clk); #2;
    check("fetch_hold", {28'b0, state}, 0);
    mem_ready = 1;

    // lw
    run_instr(6'b100011, 0, 6'b100011, 0, 0);
    check("lw_cycles", cyc, 5);
    for (int i = 0; i < 5; i++) check("lw_seq", seq[i], i);
    check("lw_reg_write_cnt", rw_cnt, 1);
    check("lw_done_cnt", done_cnt, 1);
    check("lw_back_fetch", {28'b0, state}, 0);

    // sw
    run_instr(6'b101011, 0, 6'b101011, 0, 0);
    check("sw_cycles", cyc, 4);
    check("sw_seq3", seq[3], 5);

    // R-type, op changed once past the decision points
    run_instr(6'b000000, 0, 6'b000100, 0, 0);
    check("r_cycles", cyc, 4);
    check("r_seq2", seq[2], 6);
    check("r_seq3", seq[3], 7);

    // addi
    run_instr(6'b001000, 0, 6'b001000, 0, 0);
    check("addi_cycles", cyc, 4);
    check("addi_seq3", seq[3], 11);

    // beq taken / not taken
    run_instr(6'b000100, 1, 6'b000100, 0, 0);
    check("beq_t_cycles", cyc, 3);
    check("beq_t_pc_en", br_pcen, 1);
    check("beq_t_aluop", br_aluop, 1);
    run_instr(6'b000100, 0, 6'b000100, 0, 0);
    check("beq_nt_pc_en", br_pcen, 0);
    check("beq_nt_aluop", br_aluop, 1);

    // j
    run_instr(6'b000010, 0, 6'b000010, 0, 0);
    check("j_cycles", cyc, 3);
    check("j_seq2", seq[2], 9);

    // illegal
    run_instr(6'b111111, 0, 6'b111111, 0, 0);
    check("ill_cycles", cyc, 2);
    check("ill_pulse_cnt", il_cnt, 1);
    check("ill_done_cnt", done_cnt, 1);
    check("ill_no_write", we_cnt, 0);
    check("ill_back_fetch", {28'b0, state}, 0);

    // sw with 3 stall cycles in MEM_WRITE
    run_instr(6'b101011, 0, 6'b101011, 0, 3);
    check("sw_stall_cycles", cyc, 7);
    check("sw_stall_mem_write_cnt", mw_cnt, 4);
    check("sw_stall_done_cnt", done_cnt, 1);

    // fetch stall and load stall
    run_instr(6'b000000, 0, 6'b000000, 2, 0);
    check("r_fstall_cycles", cyc, 6);
    run_instr(6'b100011, 0, 6'b100011, 0, 2);
    check("lw_mstall_cycles", cyc, 7);

    // reset in EXEC of an R-type
    op = 6'b000000; mem_ready = 1;
    step(); step();
    check("exec_reached", {28'b0, state}, 6);
    rst = 1;
    @(negedge clk);
    check("rst_exec_reg_write", {31'b0, reg_write}, 0);
    @(posedge clk); #2;
    check("rst_exec_state", {28'b0, state}, 0);
    rst = 0; mem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_reg_write", {31'b0, reg_write}, 0);
      @(posedge clk); #2;
    end
    mem_ready = 1;
    run_instr(6'b000000, 0, 6'b000000, 0, 0);
    check("post_rst_r_cycles", cyc, 4);

    // reset while MEM_WRITE is waiting
    op = 6'b101011; mem_ready = 1;
    step(); step(); step();
    check("mw_reached", {28'b0, state}, 5);
    mem_ready = 0;
    @(negedge clk);
    check("mw_wait_strobe", {31'b0, mem_write}, 1);
    @(posedge clk); #2;
    rst = 1;
    @(negedge clk);
    check("mw_rst_strobe", {31'b0, mem_write}, 0);
    @(posedge clk); #2;
    rst = 0;
    @(negedge clk);
    check("mw_after_rst_strobe", {31'b0, mem_write}, 0);
    check("mw_after_rst_state", {28'b0, state}, 0);
    @(posedge clk); #2;
    mem_ready = 1;
    run_instr(6'b001000, 0, 6'b001000, 0, 0);
    check("post_rst_addi_cycles", cyc, 4);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
